elastic_stage_reg: RTL and testbench
====================================

// Module: elastic_stage_reg
// PURPOSE
//  Parametrised elastic pipeline register for the rv32i datapath; carries one packed payload
//  (a pipeline struct, e.g. $bits(rv32i_id_ex_t)) between stages.
//  Uses a valid/ready handshake and flush-to-bubble, so stalls propagate back without a global load.
//  Counts downstream stall cycles for performance debug.
//  One instance per boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing per-field load-enable registers.
// PARAMETERS
//  WIDTH    32  payload width in bits (>=1)
//  NOP_VAL  '0  WIDTH-bit bubble value driven on out_data_o whenever out_valid_o=0
//  CNT_W    16  stall counter width (>=1)
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      reset, asynchronous, active-high
//  in_valid_i   in   1      upstream payload valid
//  in_ready_o   out  1      stage can accept this cycle
//  in_data_i    in   WIDTH  upstream payload
//  flush_i      in   1      synchronous kill of all held payloads (branch mispredict / exception)
//  out_valid_o  out  1      held payload valid
//  out_ready_i  in   1      downstream accepts this cycle
//  out_data_o   out  WIDTH  held payload; NOP_VAL when out_valid_o=0
//  stall_cnt_o  out  CNT_W  cycles with out_valid_o & !out_ready_i, saturating
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-transfer):
//    out_valid_o=0, out_data_o=NOP_VAL, stall_cnt_o=0, in_ready_o=1, skid entry empty.
//    All held data is lost.
//  - Transfers: input xfer = in_valid_i & in_ready_o; output xfer = out_valid_o & out_ready_i.
//  - Latency: payload accepted at edge N is on out_data_o after edge N.
//    Strict FIFO order; no payload is duplicated or dropped except by flush.
//  - out_data_o is a registered value; it never combinationally follows in_data_i.
//  - Main register (base build):
//    in_ready_o = !out_valid_o | out_ready_i (combinational path from out_ready_i).
//    Input xfer loads main register and sets valid; output xfer without input xfer clears valid.
//    Simultaneous input and output xfer: new payload replaces old, valid stays 1 (full throughput).
//  - Flush has priority over everything:
//    next state is empty, out_valid_o=0, out_data_o=NOP_VAL.
//    An input xfer in the same cycle is discarded.
//    in_ready_o is forced to 1 during flush, so upstream does not stall on a killed payload.
//  - Stall counter:
//    +1 per cycle with out_valid_o=1 and out_ready_i=0; holds at all-ones.
//    Cleared to 0 by flush_i; unchanged otherwise.
//  - Bubbles: out_valid_o=0 means downstream treats out_data_o (NOP_VAL) as a no-op.
//    The stage never asserts out_valid_o without an accepted input.
// CONFIGURATION
//  ELASTIC_STAGE_SKID_EN undefined:
//    single main register as above; 1 entry; in_ready_o depends combinationally on out_ready_i.
//  ELASTIC_STAGE_SKID_EN defined:
//    adds a one-entry skid register, 2 entries total; in_ready_o = !skid_valid (registered).
//    FSM with states EMPTY, FULL, SKID:
//      EMPTY: in xfer -> FULL.
//      FULL: in & out xfer -> FULL (main replaced);
//            in & !out -> SKID (payload into skid);
//            !in & out -> EMPTY.
//      SKID (in_ready_o=0): out_ready_i -> FULL (skid moves into main, skid cleared);
//            otherwise hold.
//    Flush from any state -> EMPTY, both entries cleared.
//    Latency and order are unchanged.
// TESTING
//  1 Reset mid-stream: rst=1 while out_valid_o=1
//    -> same cycle out_valid_o=0, out_data_o=NOP_VAL, stall_cnt_o=0, in_ready_o=1.
//  2 Streaming: 8 beats 0x10..0x17 with out_ready_i=1 throughout
//    -> 0x10..0x17 appear in order, one per cycle, 1 cycle after acceptance, no bubbles.
//  3 Back-pressure: hold out_ready_i=0 for 5 cycles while 0xAA is held
//    -> out_data_o stays 0xAA, stall_cnt_o=5; base build: in_ready_o=0;
//       SKID_EN: 0xBB accepted into skid, then in_ready_o=0.
//  4 Flush with simultaneous input: full with 0x55, flush_i=1 and in_valid_i=1 (0x66)
//    -> next cycle out_valid_o=0, out_data_o=NOP_VAL, stall_cnt_o=0; 0x66 never appears.
//  5 Saturation: CNT_W=2, stall 6 cycles -> stall_cnt_o sequence 1,2,3,3,3,3.
//  6 SKID_EN drain: SKID holding 0x01 (main) and 0x02 (skid), out_ready_i=1 for 2 cycles
//    -> outputs 0x01 then 0x02, in_ready_o returns to 1 after first drain.

Source files
------------

// File: rtl/elastic_stage_reg.sv
// elastic_stage_reg: elastic pipeline register with a valid/ready handshake,
// flush-to-bubble and a saturating downstream stall counter.
// Build option: define ELASTIC_STAGE_SKID_EN to add a one-entry skid register
// so that in_ready_o comes from a register instead of from out_ready_i.
module elastic_stage_reg #(
  parameter int unsigned           WIDTH   = 32,
  parameter logic [WIDTH-1:0]      NOP_VAL = '0,
  parameter int unsigned           CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_valid;
  logic             w_ready;

  // Transfer qualifiers; flush forces in_ready_o high so upstream never stalls on a killed beat
  always_comb begin
    in_ready_o = w_ready | flush_i;
    w_in_xfer  = in_valid_i & in_ready_o;
    w_out_xfer = w_valid & out_ready_i;
  end

`ifdef ELASTIC_STAGE_SKID_EN

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FULL,
    S_SKID
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_skid;

  // Readiness and validity come straight from the state register
  always_comb begin
    w_ready = (r_state != S_SKID);
    w_valid = (r_state != S_EMPTY);
  end

  // Next-state logic; flush wins from any state
  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_in_xfer) w_next = S_FULL;
        S_FULL: begin
          if (w_in_xfer && !w_out_xfer)      w_next = S_SKID;
          else if (!w_in_xfer && w_out_xfer) w_next = S_EMPTY;
        end
        S_SKID:  if (out_ready_i) w_next = S_FULL;
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_next;
  end

  // Main and skid payload registers; an empty entry always holds NOP_VAL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= NOP_VAL;
      r_skid <= NOP_VAL;
    end else if (flush_i) begin
      r_data <= NOP_VAL;
      r_skid <= NOP_VAL;
    end else begin
      case (r_state)
        S_EMPTY: if (w_in_xfer) r_data <= in_data_i;
        S_FULL: begin
          if (w_in_xfer && w_out_xfer) r_data <= in_data_i;
          else if (w_in_xfer)          r_skid <= in_data_i;
          else if (w_out_xfer)         r_data <= NOP_VAL;
        end
        S_SKID: begin
          if (out_ready_i) begin
            r_data <= r_skid;
            r_skid <= NOP_VAL;
          end
        end
        default: begin
          r_data <= NOP_VAL;
          r_skid <= NOP_VAL;
        end
      endcase
    end
  end

`else

  logic r_valid;

  // Single entry: accept when empty or when the held beat leaves this cycle
  always_comb begin
    w_valid = r_valid;
    w_ready = !r_valid | out_ready_i;
  end

  // Main register; data reverts to NOP_VAL whenever the entry empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VAL;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VAL;
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
      r_data  <= in_data_i;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VAL;
    end
  end

`endif

  // Saturating count of cycles where a valid beat is held back by downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (flush_i) begin
      r_cnt <= '0;
    end else if (w_valid && !out_ready_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Outputs are register values only
  always_comb begin
    out_valid_o = w_valid;
    out_data_o  = r_data;
    stall_cnt_o = r_cnt;
  end

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Directed self-checking bench for elastic_stage_reg (base or skid build).
module tb_elastic_stage_reg;

  localparam int unsigned W   = 8;
  localparam logic [W-1:0] NOP = 8'hE5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         flush;
  logic         out_ready;
  logic         in_ready,  in_ready2;
  logic         out_valid, out_valid2;
  logic [W-1:0] out_data,  out_data2;
  logic [15:0]  cnt;
  logic [1:0]   cnt2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  elastic_stage_reg #(.WIDTH(W), .NOP_VAL(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .stall_cnt_o(cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation
  elastic_stage_reg #(.WIDTH(W), .NOP_VAL(NOP), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .in_data_i(in_data), .flush_i(flush), .out_valid_o(out_valid2),
    .out_ready_i(out_ready), .out_data_o(out_data2), .stall_cnt_o(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data), 32'(NOP));
    chk("rst_cnt",   32'(cnt), 0);
    chk("rst_ready", 32'(in_ready), 1);
    tick(); tick();
    rst = 1'b0;

    // Streaming: 8 beats, one per cycle, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = W'(8'h10 + i);
      chk("stream_ready", 32'(in_ready), 1);
      tick();
      chk("stream_valid", 32'(out_valid), 1);
      chk("stream_data",  32'(out_data), 32'h10 + i);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 32'(out_valid), 0);
    chk("stream_end_data",  32'(out_data), 32'(NOP));
    chk("stream_cnt",       32'(cnt), 0);

    // Reset while holding a beat
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_valid", 32'(out_valid), 1);
    chk("mid_cnt",   32'(cnt), 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data",  32'(out_data), 32'(NOP));
    chk("arst_cnt",   32'(cnt), 0);
    chk("arst_ready", 32'(in_ready), 1);
    rst = 1'b0;

    // Back-pressure: hold 0xAA for 5 stalled cycles, 0xBB offered
    in_valid = 1'b1; in_data = 8'hAA;
    tick();
    chk("bp_data0", 32'(out_data), 32'hAA);
    in_data = 8'hBB;
`ifdef ELASTIC_STAGE_SKID_EN
    chk("bp_ready0", 32'(in_ready), 1);
`else
    chk("bp_ready0", 32'(in_ready), 0);
`endif
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("bp_data", 32'(out_data), 32'hAA);
      chk("bp_cnt",  32'(cnt), 32'(k));
      chk("bp_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
`ifdef ELASTIC_STAGE_SKID_EN
    chk("bp_skid_data", 32'(out_data), 32'hBB);
    tick();
`endif
    chk("bp_drain_valid", 32'(out_valid), 0);
    chk("bp_drain_data",  32'(out_data), 32'(NOP));
    chk("bp_cnt_hold",    32'(cnt), 5);

    // Flush clears the counter
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_cnt",  32'(cnt), 0);
    chk("flush_cnt2", 32'(cnt2), 0);

    // Saturation on the 2-bit counter: 1,2,3,3,3,3
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("sat_cnt2", 32'(cnt2), (k < 3) ? 32'(k) : 3);
      chk("sat_cnt",  32'(cnt), 32'(k));
    end

    // Flush with simultaneous input: 0x66 must be discarded
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    tick();
    chk("fl_full", 32'(out_data), 32'h55);
    out_ready = 1'b0; in_data = 8'h66; flush = 1'b1;
    #1;
    chk("fl_ready", 32'(in_ready), 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_data",  32'(out_data), 32'(NOP));
    chk("fl_cnt",   32'(cnt), 0);
    out_ready = 1'b1;
    tick();
    chk("fl_no66_valid", 32'(out_valid), 0);
    chk("fl_no66_data",  32'(out_data), 32'(NOP));

`ifdef ELASTIC_STAGE_SKID_EN
    // Skid drain: 0x01 in main, 0x02 in skid
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_data = 8'h02;
    tick();
    in_valid = 1'b0;
    chk("sk_ready0", 32'(in_ready), 0);
    chk("sk_data0",  32'(out_data), 32'h01);
    out_ready = 1'b1;
    tick();
    chk("sk_data1",  32'(out_data), 32'h02);
    chk("sk_valid1", 32'(out_valid), 1);
    chk("sk_ready1", 32'(in_ready), 1);
    tick();
    chk("sk_valid2", 32'(out_valid), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
